// File: rtl/data_mem_hs.sv
// Byte-addressed RV32 data memory (LB/LH/LW/LBU/LHU, SB/SH/SW) behind valid/ready request/response channels.
// Latency accept->rsp_valid: loads RD_LAT+1 cycles, stores and errors 2 cycles; one request outstanding.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_valid & rsp_ready.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_we, req_size, req_unsigned, req_addr, req_wdata
//   rsp_valid/rsp_ready   response handshake; rsp_rdata (extended load data, 0 otherwise), rsp_err
//   busy                  high whenever the FSM is outside IDLE
module data_mem_hs #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT   = 3'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [2:0]  cnt;
  logic        lat_we;
  logic        lat_err;
  logic [31:0] ld_dat;

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             req_err;
  logic [3:0]       be;
  logic [31:0]      wdat_rep;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      ld_ext;

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[IDX_W+1:2];
  assign lane   = req_addr[1:0];

  // Alignment, size and range checks on the raw request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = lane[0];
      2'b10:   req_err = (lane != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (req_addr[ADDR_W-1:IDX_W+2] != '0) req_err = 1'b1;
  end

  // Store data is replicated across lanes so each enabled lane picks up the right byte.
  always_comb begin
    be       = 4'b0000;
    wdat_rep = req_wdata;
    case (req_size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wdat_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdat_rep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be       = 4'b1111;
        wdat_rep = req_wdata;
      end
      default: begin
        be       = 4'b0000;
        wdat_rep = req_wdata;
      end
    endcase
  end

  // Load path: read at accept, align the addressed byte/half to bit 0, then extend.
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_ext = 32'h0;
    case (req_size)
      2'b00:   ld_ext = req_unsigned ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = req_unsigned ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   ld_ext = rd_word;
      default: ld_ext = 32'h0;
    endcase
  end

  // The array has no reset; a store commits on its accept edge, so a later
  // reset cannot undo it. The reset guard stops a write while req_ready is
  // forced high during reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdat_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 3'd0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      ld_dat    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= 3'd1;
            lat_we    <= req_we;
            lat_err   <= req_err;
            ld_dat    <= (req_we || req_err) ? 32'h0 : ld_ext;
          end
        end
        S_WAIT: begin
          // Stores and errors leave after one cycle; loads wait out RD_LAT.
          if (lat_we || lat_err || cnt == LAT) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_dat;
            rsp_err   <= lat_err;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
